// File: rtl/i2s_to_pcm_receiver_if.sv
// Bus bundle between an I2S receiver and its surroundings: the external
// I2S pins and error clear going in, the PCM words, strobes and status coming out.
interface i2s_to_pcm_receiver_if #(
    parameter int DATA_WIDTH = 24
);
    logic                  i2s_bclk;
    logic                  i2s_lrclk;
    logic                  i2s_sdata;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] l_data;
    logic                  l_data_en;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_en;
    logic                  locked;
    logic                  frame_err;

    // Side that drives the I2S stream and consumes the PCM words.
    modport master (
        output i2s_bclk, i2s_lrclk, i2s_sdata, err_clr,
        input  l_data, l_data_en, r_data, r_data_en, locked, frame_err
    );

    // Receiver side.
    modport slave (
        input  i2s_bclk, i2s_lrclk, i2s_sdata, err_clr,
        output l_data, l_data_en, r_data, r_data_en, locked, frame_err
    );
endinterface

// File: rtl/i2s_to_pcm_receiver.sv
// I2S to parallel PCM receiver. The external bclk is oversampled on the
// system clock; every bit is taken on a detected bclk rising edge. Slots are
// delimited by lrclk changes, length-checked, and completed words are
// presented with a one-clk strobe per channel.
module i2s_to_pcm_receiver #(
    parameter int DATA_WIDTH    = 24,
    parameter int MIN_SLOT_BITS = 16,
    parameter int MAX_SLOT_BITS = 32,
    parameter int TIMEOUT_CLKS  = 256
) (
    input  logic                  clk,
    input  logic                  audio_en,
    i2s_to_pcm_receiver_if.slave  bus
);

    localparam int CNT_W = $clog2(MAX_SLOT_BITS + 2);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;

    // bclk: [0] first sync stage, [1] synchronized, [2] one more for edge detect
    logic [2:0]            bclk_q;
    logic [1:0]            lr_q;
    logic [1:0]            sd_q;

    logic                  prev_lr_q, prev_lr_d;
    logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [DATA_WIDTH-1:0] l_data_q, l_data_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  l_en_q, l_en_d;
    logic                  r_en_q, r_en_d;
    logic                  err_q, err_d;

    logic                  bclk_rise;
    logic                  lr_s;
    logic                  sd_s;
    logic                  boundary;
    logic                  timeout;
    logic [CNT_W-1:0]      n_bits;
    logic                  n_ok;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] word;

    assign bclk_rise = bclk_q[1] & ~bclk_q[2];
    assign lr_s      = lr_q[1];
    assign sd_s      = sd_q[1];
    assign boundary  = bclk_rise && (lr_s != prev_lr_q);

    // The counter stops at TIMEOUT_CLKS, so the timeout fires exactly once
    // per bclk outage; a rise in the same cycle always prevents it.
    assign timeout   = !bclk_rise && (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));

    // Slot length including the bit taken at the current rise (saturating).
    assign n_bits = (int'(slot_cnt_q) == MAX_SLOT_BITS + 1) ? slot_cnt_q
                                                              : slot_cnt_q + CNT_W'(1);
    assign n_ok   = (int'(n_bits) >= MIN_SLOT_BITS) && (int'(n_bits) <= MAX_SLOT_BITS);

    // Place the current bit at its MSB-first position; bits past DATA_WIDTH
    // are dropped and short slots stay zero-padded at the bottom.
    always_comb begin
        word    = shreg_q;
        bit_idx = '0;
        if (int'(slot_cnt_q) < DATA_WIDTH) begin
            bit_idx       = IDX_W'(DATA_WIDTH - 1 - int'(slot_cnt_q));
            word[bit_idx] = sd_s;
        end
    end

    // Timeout counter: cleared by every bclk rise, otherwise counts up to the limit.
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (bclk_rise) begin
            to_cnt_d = '0;
        end else if (int'(to_cnt_q) != TIMEOUT_CLKS) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    // Next-state logic: slot assembly, slot evaluation and output updates.
    always_comb begin
        state_d    = state_q;
        prev_lr_d  = prev_lr_q;
        slot_cnt_d = slot_cnt_q;
        shreg_d    = shreg_q;
        l_data_d   = l_data_q;
        r_data_d   = r_data_q;
        l_en_d     = 1'b0;
        r_en_d     = 1'b0;
        err_d      = err_q & ~bus.err_clr;

        if (timeout) begin
            state_d    = SEARCH;
            slot_cnt_d = '0;
            shreg_d    = '0;
            if (state_q == LOCKED) begin
                err_d = 1'b1;
            end
        end else if (bclk_rise) begin
            prev_lr_d = lr_s;
            if (boundary) begin
                slot_cnt_d = '0;
                shreg_d    = '0;
                case (state_q)
                    SEARCH: state_d = ALIGN;
                    ALIGN: begin
                        if (n_ok) begin
                            state_d = LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (n_ok) begin
                            // the slot that just ended belongs to the previous lrclk
                            if (prev_lr_q) begin
                                r_data_d = word;
                                r_en_d   = 1'b1;
                            end else begin
                                l_data_d = word;
                                l_en_d   = 1'b1;
                            end
                        end else begin
                            err_d   = 1'b1;
                            state_d = ALIGN;
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end else begin
                shreg_d = word;
                if (int'(slot_cnt_q) != MAX_SLOT_BITS + 1) begin
                    slot_cnt_d = slot_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Synchronizers, FSM state and all registered outputs, cleared while audio_en is low.
    always_ff @(posedge clk) begin
        if (!audio_en) begin
            bclk_q     <= '0;
            lr_q       <= '0;
            sd_q       <= '0;
            state_q    <= SEARCH;
            prev_lr_q  <= 1'b0;
            slot_cnt_q <= '0;
            shreg_q    <= '0;
            to_cnt_q   <= '0;
            l_data_q   <= '0;
            r_data_q   <= '0;
            l_en_q     <= 1'b0;
            r_en_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            bclk_q     <= {bclk_q[1:0], bus.i2s_bclk};
            lr_q       <= {lr_q[0], bus.i2s_lrclk};
            sd_q       <= {sd_q[0], bus.i2s_sdata};
            state_q    <= state_d;
            prev_lr_q  <= prev_lr_d;
            slot_cnt_q <= slot_cnt_d;
            shreg_q    <= shreg_d;
            to_cnt_q   <= to_cnt_d;
            l_data_q   <= l_data_d;
            r_data_q   <= r_data_d;
            l_en_q     <= l_en_d;
            r_en_q     <= r_en_d;
            err_q      <= err_d;
        end
    end

    assign bus.l_data    = l_data_q;
    assign bus.l_data_en = l_en_q;
    assign bus.r_data    = r_data_q;
    assign bus.r_data_en = r_en_q;
    assign bus.locked    = (state_q == LOCKED);
    assign bus.frame_err = err_q;

endmodule
